// File: rtl/bk_mp_add_seq.sv
// Multi-precision adder: word pairs in LSW-first, one registered sum word out per accepted pair, carry chained across cycles.
// Latency 1 cycle; in_ready = !out_valid || out_ready, so a stalled output holds every out_* stable and blocks input.

module bk_adder_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    logic [31:0] w_gen;
    logic [31:0] w_prop;
    logic [31:0] w_gg;
    logic [31:0] w_pp;

    // Brent-Kung prefix: up-sweep builds power-of-two spans, down-sweep fills the gaps.
    always_comb begin
        w_gen  = i_a & i_b;
        w_prop = i_a ^ i_b;
        w_gg   = w_gen;
        w_pp   = w_prop;
        w_gg[0] = w_gen[0] | (w_prop[0] & i_cin);
        for (int l = 0; l < 5; l++) begin
            for (int i = (2 << l) - 1; i < 32; i += (2 << l)) begin
                w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << l)]);
                w_pp[i] = w_pp[i] & w_pp[i - (1 << l)];
            end
        end
        for (int l = 3; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < 32; i += (2 << l)) begin
                w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << l)]);
                w_pp[i] = w_pp[i] & w_pp[i - (1 << l)];
            end
        end
    end

    assign o_sum  = w_prop ^ {w_gg[30:0], i_cin};
    assign o_cout = w_gg[31];

endmodule

module bk_mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_last,
    output logic        out_cout
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_CHAIN = 1'b1
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_cy;
    logic            r_out_valid;
    logic [31:0]     r_out_sum;
    logic            r_out_last;
    logic            r_out_cout;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_last;
    logic            w_cin_sel;
    logic [31:0]     w_sum;
    logic            w_cout;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready && !flush;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_cin_sel  = (r_state == ST_FIRST) ? in_cin : r_cy;

    bk_adder_32bit u_adder (
        .i_a    (in_a),
        .i_b    (in_b),
        .i_cin  (w_cin_sel),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_FIRST;
            r_idx       <= '0;
            r_cy        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
        end else if (flush) begin
            // Abandon the operation; out_sum is deliberately left as-is.
            r_state     <= ST_FIRST;
            r_idx       <= '0;
            r_cy        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_last  <= w_last;
            r_out_cout  <= w_last ? w_cout : 1'b0;
            r_cy        <= w_cout;
            if (w_last) begin
                r_idx   <= '0;
                r_state <= ST_FIRST;
            end else begin
                r_idx   <= r_idx + IW'(1);
                r_state <= ST_CHAIN;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_last  = r_out_last;
    assign out_cout  = r_out_cout;

endmodule

// File: doc/bk_mp_add_seq.md
# bk_mp_add_seq

Multi-precision add sequencer that sits directly upstream of `bk_adder_32bit`. It accepts two wide operands as a valid/ready stream of 32-bit word pairs, least-significant word first. It drives one internal `bk_adder_32bit` instance per word, chaining the carry across cycles through a register. Sum words leave on a registered valid/ready stream, and the final carry-out is flagged with the last word.

## Interface
- `WORDS`, default 4: 32-bit words per operand; legal range 1..256.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `flush`  in  1: synchronous abort of the operation in progress.
- `in_valid`  in  1: input word pair valid.
- `in_ready`  out  1: sequencer can accept a word pair this cycle.
- `in_a`  in  32: operand A word.
- `in_b`  in  32: operand B word.
- `in_cin`  in  1: operation carry-in; sampled only on word 0.
- `out_valid`  out  1: output word valid.
- `out_ready`  in  1: consumer accepts the output word.
- `out_sum`  out  32: sum word.
- `out_last`  out  1: this is word `WORDS-1` of the result.
- `out_cout`  out  1: final carry-out; meaningful only when `out_last`=1, otherwise 0.

## Operation
- **State.**
  - Word index `idx`, width clog2(WORDS), minimum 1 bit.
  - Carry register `cy`.
  - Output register set {`out_valid`, `out_sum`, `out_last`, `out_cout`}.
- **Two-state FSM.**
  - FIRST: `idx`=0; adder carry-in = `in_cin`.
  - CHAIN: `idx`>0; adder carry-in = `cy`.
- **Accept.** A transfer occurs when `in_valid && in_ready`.
- **Ready rule.** `in_ready = !out_valid || out_ready`. It is combinational and does not depend on `in_valid`.
- **On accept:**
  - `out_sum` ← adder sum of `in_a` + `in_b` + selected carry-in.
  - `out_last` ← (`idx`==WORDS-1).
  - `out_cout` ← adder cout if last, else 0.
  - `cy` ← adder cout.
  - `out_valid` ← 1.
  - `idx` ← `idx`+1, or wraps to 0 after the last word, which returns the FSM to FIRST.
- **Output drain.** On `out_valid && out_ready` with no simultaneous accept, `out_valid` ← 0. With a simultaneous accept, the new word loads and `out_valid` stays 1.
- **WORDS=1.** Every word is FIRST and last. The block behaves as a registered single-word adder, and `cy` is unused.
- **Arithmetic.** Modulo 2^(32·WORDS); the carry out of the top word appears only on `out_cout`.
- **flush=1.**
  - Clears `idx`, `cy`, `out_valid`, `out_last` and `out_cout` next edge; `out_sum` is held.
  - No input is accepted that cycle, even if `in_ready`=1.
  - Flush has priority over accept and drain.
- **Reset.** `rst` asserted at any time, including mid-operation, abandons the partial result. No partial word is emitted after reset.

## Timing
- **Reset values.** `out_valid`=0, `out_sum`=0, `out_last`=0, `out_cout`=0, `idx`=0, `cy`=0, FSM=FIRST. After reset `in_ready`=1.
- **Latency.** 1 cycle: a word accepted at edge N is visible on `out_*` after edge N.
- **Throughput.** 1 word/cycle while `out_ready`=1. A full operation takes WORDS accepted cycles.
- **Back-to-back operations.** The word after a last word is treated as word 0 of a new operation with no bubble; `in_cin` is sampled again.
- **Backpressure.** While `out_valid && !out_ready`, all `out_*` hold stable and `in_ready`=0.
- **Input gaps.** Gaps between words of one operation (`in_valid`=0) are allowed indefinitely; `cy` and `idx` hold.
- **Combinational path.** The only combinational input→output path is `out_ready`→`in_ready`.

## Test plan
- **WORDS=1 carry-in and overflow.**
  - 56+78, cin 0 → `out_sum`=134, `out_last`=1, `out_cout`=0, one cycle after accept.
  - 567+435, cin 1 → `out_sum`=1003.
  - 0xFFFFFFFF+0x00000001, cin 0 → `out_sum`=0, `out_cout`=1.
- **WORDS=2 carry chain.** A=0x00000000_FFFFFFFF, B=0x00000000_00000001, cin 0 → word 0 0x00000000 with last=0, then word 1 0x00000001 with last=1, cout=0.
- **WORDS=4 all-ones.** A=all ones, B=0, cin 1 → four words 0x00000000, last only on word 3, `out_cout`=1. Then, back-to-back, 1+1 (word 0 = 1, rest 0) with cin 0 → word 0 = 2, cout=0, confirming `cy` does not leak across operations.
- **Backpressure.**
  - Hold `out_ready`=0 for 3 cycles mid-operation with `in_valid`=1 → `in_ready`=0 and `out_*` stable.
  - Release `out_ready` → next word accepted the same cycle, and the sum sequence equals the no-stall run.
- **Flush mid-operation.**
  - WORDS=4: accept 2 words, assert `flush` for 1 cycle → `out_valid`=0, and nothing is accepted that cycle.
  - Next operation 5+7, cin 0 → word 0 = 12 with `in_cin` used, not the stale carry.
- **Async reset mid-operation.** Assert `rst` between clock edges after word 1 → outputs read zeros immediately. The next operation starts at word 0 with correct results.
